// File: rtl/stage_memory_pkg.sv
// Shared types for the MEM pipeline stage: control bundles, funct3 access codes
// and the bus FSM state type.
package stage_memory_pkg;

    typedef struct packed {
        logic MemRead;
        logic MemWrite;
    } MEM_Control_t;

    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
    } WB_Control_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        BUS
    } mem_state_t;

endpackage

// File: rtl/stage_memory_load_store_align.sv
// Byte-lane steering for stores, lane select and extension for loads, and the
// alignment check for the issuing access.
module load_store_align
    import stage_memory_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic [31:0] store_wdata,
    output logic [3:0]  store_byte_en,
    output logic        misaligned,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_offset,
    input  logic [31:0] load_raw,
    output logic [31:0] load_data
);
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        store_wdata   = store_data;
        store_byte_en = 4'b1111;
        misaligned    = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                store_wdata   = {4{store_data[7:0]}};
                store_byte_en = 4'b0001 << offset;
            end
            F3_H, F3_HU: begin
                store_wdata   = {2{store_data[15:0]}};
                store_byte_en = offset[1] ? 4'b1100 : 4'b0011;
                misaligned    = offset[0];
            end
            F3_W:    misaligned = |offset;
            default: misaligned = 1'b1;
        endcase
    end

    assign shifted = load_raw >> {load_offset, 3'b000};
    assign lane_b  = shifted[7:0];
    assign lane_h  = load_offset[1] ? load_raw[31:16] : load_raw[15:0];

    always_comb begin
        load_data = load_raw;
        case (load_funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'b0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'b0, lane_h};
            default: load_data = load_raw;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// MEM pipeline stage: issues one data-bus access per load/store, stalls the
// pipeline until ack or timeout, and registers the MEM/WB outputs.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    input  logic         i_Valid,
    input  MEM_Control_t i_MEM_Control,
    input  WB_Control_t  i_WB_Control,
    input  logic [2:0]   i_Funct3,
    input  logic [31:0]  i_AluResult,
    input  logic [31:0]  i_rs2Value,
    input  logic [4:0]   i_rd,
    output logic         o_DBus_Req,
    output logic         o_DBus_We,
    output logic [31:0]  o_DBus_Addr,
    output logic [31:0]  o_DBus_WData,
    output logic [3:0]   o_DBus_ByteEn,
    input  logic         i_DBus_Ack,
    input  logic [31:0]  i_DBus_RData,
    output logic         o_Stall,
    output logic         o_Valid,
    output WB_Control_t  o_WB_Control,
    output logic [31:0]  o_AluResult,
    output logic [31:0]  o_LoadData,
    output logic [4:0]   o_rd,
    output logic         o_Misaligned,
    output logic         o_BusError
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t    state;
    logic [CW-1:0] count;
    logic [31:0]   alu_q;
    logic [2:0]    funct3_q;
    logic [4:0]    rd_q;
    WB_Control_t   wb_q;

    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        misaligned;
    logic [31:0] ld_data;
    logic        mem_op;
    logic        start;
    logic        timeout;

    load_store_align u_align (
        .funct3        (i_Funct3),
        .offset        (i_AluResult[1:0]),
        .store_data    (i_rs2Value),
        .store_wdata   (st_wdata),
        .store_byte_en (st_be),
        .misaligned    (misaligned),
        .load_funct3   (funct3_q),
        .load_offset   (alu_q[1:0]),
        .load_raw      (i_DBus_RData),
        .load_data     (ld_data)
    );

    assign mem_op      = i_Valid & (i_MEM_Control.MemRead | i_MEM_Control.MemWrite);
    assign start       = (state == IDLE) & mem_op & ~misaligned;
    // Timeout fires on the last permitted wait cycle so Req is high exactly TIMEOUT_CYCLES cycles.
    assign timeout     = (state == BUS) & (count == CW'(TIMEOUT_CYCLES - 1));
    assign o_Stall     = i_Reset & (start | ((state == BUS) & ~i_DBus_Ack & ~timeout));
    assign o_DBus_Addr = {alu_q[31:2], 2'b00};

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state         <= IDLE;
            count         <= '0;
            alu_q         <= '0;
            funct3_q      <= '0;
            rd_q          <= '0;
            wb_q          <= '0;
            o_DBus_Req    <= 1'b0;
            o_DBus_We     <= 1'b0;
            o_DBus_WData  <= '0;
            o_DBus_ByteEn <= '0;
            o_Valid       <= 1'b0;
            o_WB_Control  <= '0;
            o_AluResult   <= '0;
            o_LoadData    <= '0;
            o_rd          <= '0;
            o_Misaligned  <= 1'b0;
            o_BusError    <= 1'b0;
        end else begin
            o_Valid               <= 1'b0;
            o_WB_Control.RegWrite <= 1'b0;
            o_Misaligned          <= 1'b0;
            o_BusError            <= 1'b0;
            case (state)
                IDLE: begin
                    o_Valid                <= i_Valid & ~start;
                    o_WB_Control.MemToReg  <= i_WB_Control.MemToReg;
                    o_WB_Control.RegWrite  <= i_Valid & ~mem_op & i_WB_Control.RegWrite;
                    o_Misaligned           <= mem_op & misaligned;
                    o_AluResult            <= i_AluResult;
                    o_LoadData             <= '0;
                    o_rd                   <= i_rd;
                    if (start) begin
                        state         <= BUS;
                        count         <= '0;
                        alu_q         <= i_AluResult;
                        funct3_q      <= i_Funct3;
                        rd_q          <= i_rd;
                        wb_q          <= i_WB_Control;
                        o_DBus_Req    <= 1'b1;
                        o_DBus_We     <= i_MEM_Control.MemWrite;
                        o_DBus_WData  <= st_wdata;
                        o_DBus_ByteEn <= st_be;
                    end
                end
                BUS: begin
                    if (i_DBus_Ack || timeout) begin
                        state        <= IDLE;
                        o_DBus_Req   <= 1'b0;
                        o_Valid      <= 1'b1;
                        o_WB_Control <= wb_q;
                        o_AluResult  <= alu_q;
                        o_rd         <= rd_q;
                        o_LoadData   <= o_DBus_We ? '0 : ld_data;
                        if (!i_DBus_Ack) begin
                            o_WB_Control.RegWrite <= 1'b0;
                            o_BusError            <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Directed and randomized checks of stage_memory against an access-level
// reference model (timeout shortened to 4 cycles).
module tb_stage_memory;
    import stage_memory_pkg::*;

    localparam int unsigned T = 4;

    logic         i_Clock;
    logic         i_Reset;
    logic         i_Valid;
    MEM_Control_t i_MEM_Control;
    WB_Control_t  i_WB_Control;
    logic [2:0]   i_Funct3;
    logic [31:0]  i_AluResult;
    logic [31:0]  i_rs2Value;
    logic [4:0]   i_rd;
    logic         o_DBus_Req;
    logic         o_DBus_We;
    logic [31:0]  o_DBus_Addr;
    logic [31:0]  o_DBus_WData;
    logic [3:0]   o_DBus_ByteEn;
    logic         i_DBus_Ack;
    logic [31:0]  i_DBus_RData;
    logic         o_Stall;
    logic         o_Valid;
    WB_Control_t  o_WB_Control;
    logic [31:0]  o_AluResult;
    logic [31:0]  o_LoadData;
    logic [4:0]   o_rd;
    logic         o_Misaligned;
    logic         o_BusError;

    int unsigned tests = 0;
    int unsigned fails = 0;

    stage_memory #(.TIMEOUT_CYCLES(T)) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_Valid       (i_Valid),
        .i_MEM_Control (i_MEM_Control),
        .i_WB_Control  (i_WB_Control),
        .i_Funct3      (i_Funct3),
        .i_AluResult   (i_AluResult),
        .i_rs2Value    (i_rs2Value),
        .i_rd          (i_rd),
        .o_DBus_Req    (o_DBus_Req),
        .o_DBus_We     (o_DBus_We),
        .o_DBus_Addr   (o_DBus_Addr),
        .o_DBus_WData  (o_DBus_WData),
        .o_DBus_ByteEn (o_DBus_ByteEn),
        .i_DBus_Ack    (i_DBus_Ack),
        .i_DBus_RData  (i_DBus_RData),
        .o_Stall       (o_Stall),
        .o_Valid       (o_Valid),
        .o_WB_Control  (o_WB_Control),
        .o_AluResult   (o_AluResult),
        .o_LoadData    (o_LoadData),
        .o_rd          (o_rd),
        .o_Misaligned  (o_Misaligned),
        .o_BusError    (o_BusError)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_Clock);
        @(negedge i_Clock);
    endtask

    // One instruction through the stage; delay = BUS cycle on which ack arrives
    // (delay >= T means the slave never answers).
    task automatic run_op(input logic v, input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rw, input int unsigned delay, input logic [31:0] rdata);
        logic        mem, mis, timed_out;
        int unsigned width, off;
        logic [31:0] exp_wd, exp_ld, b, h;
        logic [3:0]  exp_be;

        mem = v && (mr || mw);
        off = addr % 4;
        case (f3)
            3'd0, 3'd4: width = 1;
            3'd1, 3'd5: width = 2;
            3'd2:       width = 4;
            default:    width = 0;
        endcase
        mis = (width == 0) || (off % width != 0);

        if (width == 1) begin
            exp_wd = (rs2 & 32'hFF) * 32'h01010101;
            exp_be = 4'(1 << off);
        end else if (width == 2) begin
            exp_wd = (rs2 & 32'hFFFF) * 32'h00010001;
            exp_be = (off >= 2) ? 4'hC : 4'h3;
        end else begin
            exp_wd = rs2;
            exp_be = 4'hF;
        end
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    exp_ld = (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd4:    exp_ld = b;
            3'd1:    exp_ld = (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd5:    exp_ld = h;
            default: exp_ld = rdata;
        endcase

        i_Valid                 = v;
        i_MEM_Control.MemRead   = mr;
        i_MEM_Control.MemWrite  = mw;
        i_WB_Control.RegWrite   = rw;
        i_WB_Control.MemToReg   = mr;
        i_Funct3                = f3;
        i_AluResult             = addr;
        i_rs2Value              = rs2;
        i_rd                    = rd;
        i_DBus_Ack              = 1'b0;
        i_DBus_RData            = $urandom;
        #1;
        check1("stall_issue", o_Stall, mem && !mis);
        check1("req_issue", o_DBus_Req, 1'b0);
        next_cycle();

        if (mem && !mis) begin
            timed_out = 1'b1;
            for (int unsigned k = 0; k < T; k++) begin
                check1("req_bus", o_DBus_Req, 1'b1);
                check32("addr_bus", o_DBus_Addr, addr & 32'hFFFFFFFC);
                check1("we_bus", o_DBus_We, mw);
                if (mw) begin
                    check32("wdata_bus", o_DBus_WData, exp_wd);
                    check32("byteen_bus", {28'b0, o_DBus_ByteEn}, {28'b0, exp_be});
                end
                check1("bubble_valid", o_Valid, 1'b0);
                check1("bubble_regwrite", o_WB_Control.RegWrite, 1'b0);
                if (k == delay) begin
                    i_DBus_Ack   = 1'b1;
                    i_DBus_RData = rdata;
                    timed_out    = 1'b0;
                    #1;
                    check1("stall_ack", o_Stall, 1'b0);
                end else begin
                    i_DBus_Ack   = 1'b0;
                    i_DBus_RData = $urandom;
                    #1;
                    check1("stall_wait", o_Stall, k != T - 1);
                end
                next_cycle();
                i_DBus_Ack = 1'b0;
                if (!timed_out) break;
            end
            check1("done_valid", o_Valid, 1'b1);
            check1("done_req", o_DBus_Req, 1'b0);
            check1("done_buserror", o_BusError, timed_out);
            check1("done_misaligned", o_Misaligned, 1'b0);
            check1("done_regwrite", o_WB_Control.RegWrite, !timed_out && rw);
            check32("done_rd", {27'b0, o_rd}, {27'b0, rd});
            check32("done_alu", o_AluResult, addr);
            if (!timed_out && !mw) check32("load_data", o_LoadData, exp_ld);
        end else begin
            check1("pass_valid", o_Valid, v);
            check1("pass_regwrite", o_WB_Control.RegWrite, v && !mem && rw);
            check1("pass_misaligned", o_Misaligned, mem && mis);
            check1("pass_buserror", o_BusError, 1'b0);
            check1("pass_req", o_DBus_Req, 1'b0);
            if (v) begin
                check32("pass_rd", {27'b0, o_rd}, {27'b0, rd});
                check32("pass_alu", o_AluResult, addr);
            end
        end
    endtask

    initial begin
        i_Reset       = 1'b0;
        i_Valid       = 1'b0;
        i_MEM_Control = '0;
        i_WB_Control  = '0;
        i_Funct3      = '0;
        i_AluResult   = '0;
        i_rs2Value    = '0;
        i_rd          = '0;
        i_DBus_Ack    = 1'b0;
        i_DBus_RData  = '0;
        @(negedge i_Clock);
        next_cycle();
        next_cycle();

        // Reset state, with a live load presented to prove the stall is masked.
        i_Valid               = 1'b1;
        i_MEM_Control.MemRead = 1'b1;
        i_Funct3              = 3'b010;
        #1;
        check1("rst_stall", o_Stall, 1'b0);
        check1("rst_req", o_DBus_Req, 1'b0);
        check1("rst_valid", o_Valid, 1'b0);
        check1("rst_regwrite", o_WB_Control.RegWrite, 1'b0);
        check1("rst_misaligned", o_Misaligned, 1'b0);
        check1("rst_buserror", o_BusError, 1'b0);
        check32("rst_loaddata", o_LoadData, 32'h0);
        check32("rst_alu", o_AluResult, 32'h0);
        check32("rst_addr", o_DBus_Addr, 32'h0);
        i_Valid = 1'b0;
        i_Reset = 1'b1;
        next_cycle();

        // Ack while idle must not produce anything.
        i_DBus_Ack = 1'b1;
        next_cycle();
        check1("idle_ack_valid", o_Valid, 1'b0);
        check1("idle_ack_req", o_DBus_Req, 1'b0);
        i_DBus_Ack = 1'b0;

        // Directed cases
        run_op(1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd3, 1, 0, 32'hDEADBEEF);
        run_op(1, 1, 0, 3'b000, 32'h103, 32'h0, 5'd4, 1, 0, 32'h80FFFFFF);
        run_op(1, 1, 0, 3'b100, 32'h103, 32'h0, 5'd5, 1, 0, 32'h80FFFFFF);
        run_op(1, 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 0, 1, 32'h0);
        run_op(1, 1, 0, 3'b010, 32'h101, 32'h0, 5'd6, 1, 0, 32'h0);
        run_op(1, 1, 0, 3'b011, 32'h100, 32'h0, 5'd6, 1, 0, 32'h0);
        run_op(1, 1, 0, 3'b010, 32'h400, 32'h0, 5'd7, 1, 99, 32'h0);
        run_op(1, 0, 0, 3'b000, 32'h55AA55AA, 32'h0, 5'd8, 1, 0, 32'h0);
        run_op(1, 1, 0, 3'b101, 32'h402, 32'h0, 5'd9, 1, T - 1, 32'h8001_7FFF);
        run_op(1, 1, 1, 3'b000, 32'h501, 32'hA5, 5'd10, 0, 2, 32'h0);

        // Reset in the second BUS cycle abandons the access; a late ack is ignored.
        i_Valid               = 1'b1;
        i_MEM_Control.MemRead = 1'b1;
        i_MEM_Control.MemWrite= 1'b0;
        i_WB_Control.RegWrite = 1'b1;
        i_Funct3              = 3'b010;
        i_AluResult           = 32'h300;
        i_rd                  = 5'd11;
        #1;
        check1("r36_stall", o_Stall, 1'b1);
        next_cycle();
        check1("r36_req1", o_DBus_Req, 1'b1);
        next_cycle();
        check1("r36_req2", o_DBus_Req, 1'b1);
        i_Reset = 1'b0;
        #1;
        check1("r36_stall_rst", o_Stall, 1'b0);
        next_cycle();
        check1("r36_req_rst", o_DBus_Req, 1'b0);
        check1("r36_valid_rst", o_Valid, 1'b0);
        check1("r36_regwrite_rst", o_WB_Control.RegWrite, 1'b0);
        i_Valid    = 1'b0;
        i_Reset    = 1'b1;
        i_DBus_Ack = 1'b1;
        #1;
        check1("r36_stall_ack", o_Stall, 1'b0);
        next_cycle();
        check1("r36_req_late", o_DBus_Req, 1'b0);
        check1("r36_valid_late", o_Valid, 1'b0);
        check1("r36_regwrite_late", o_WB_Control.RegWrite, 1'b0);
        i_DBus_Ack = 1'b0;

        // Randomized mix of all instruction kinds, alignments and ack latencies.
        for (int i = 0; i < 80; i++) begin
            logic v, mr, mw;
            int unsigned kind;
            kind = $urandom_range(0, 9);
            v    = (kind != 0);
            mr   = (kind >= 2 && kind <= 5) || kind == 8;
            mw   = (kind >= 6);
            run_op(v, mr, mw, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, T + 1), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the number of bus-wait cycles before the access is aborted.
REQ-002 SHALL have port i_Clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port i_Valid  in  1  EX/MEM register holds a live instruction.
REQ-005 SHALL have port i_MEM_Control  in  MEM_Control_t  MemRead, MemWrite.
REQ-006 SHALL have port i_WB_Control  in  WB_Control_t  RegWrite and the rest, passed through.
REQ-007 SHALL have port i_Funct3  in  3  access width and sign (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101).
REQ-008 SHALL have ports i_AluResult  in  32  effective address or ALU value; i_rs2Value  in  32  store data; i_rd  in  5  destination register.
REQ-009 SHALL have bus ports o_DBus_Req out 1, o_DBus_We out 1, o_DBus_Addr out 32 (word-aligned, [1:0]=0), o_DBus_WData out 32, o_DBus_ByteEn out 4, i_DBus_Ack in 1, i_DBus_RData in 32.
REQ-010 SHALL have outputs o_Stall out 1 (hold EX/MEM and earlier stages), o_Valid out 1, o_WB_Control out WB_Control_t, o_AluResult out 32, o_LoadData out 32, o_rd out 5, o_Misaligned out 1, o_BusError out 1.

Function
REQ-011 SHALL use the FSM states IDLE and BUS.
REQ-012 A non-memory instruction (valid, MemRead=MemWrite=0) SHALL pass to the MEM/WB outputs in 1 cycle with o_Stall=0.
REQ-013 In IDLE, a valid, aligned memory op SHALL assert o_Stall combinationally, register the address/data/byte-enables, and move to BUS.
REQ-014 In BUS, o_DBus_Req SHALL be 1 and address/WData/ByteEn/We SHALL be held stable until the cycle in which i_DBus_Ack=1.
REQ-015 o_Stall SHALL equal (IDLE & valid aligned mem op) | (BUS & !i_DBus_Ack & !timeout).
REQ-016 On the ack cycle the block SHALL capture load data, return to IDLE, and present o_Valid=1 on the following cycle; minimum load/store latency is 2 cycles with 1 stall cycle.
REQ-017 While stalled, the MEM/WB outputs SHALL carry a bubble (o_Valid=0, o_WB_Control.RegWrite=0).
REQ-018 Store lanes: SB SHALL drive WData={4{rs2[7:0]}} with ByteEn=1<<addr[1:0]; SH SHALL drive {2{rs2[15:0]}} with ByteEn=0011 or 1100 by addr[1]; SW SHALL drive rs2 with ByteEn=1111.
REQ-019 Loads SHALL select the lane by addr[1:0]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-020 Halfword access with addr[0]=1, or word access with addr[1:0]!=0, SHALL be treated as misaligned: no bus request, no stall, o_Misaligned=1 for one cycle alongside o_Valid=1, RegWrite forced 0.
REQ-021 Undefined Funct3 values (011, 110, 111) with a memory op SHALL be handled as misaligned.
REQ-022 When MemRead and MemWrite are both 1, the access SHALL be performed as a write.
REQ-023 A wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack; when it reaches TIMEOUT_CYCLES the block SHALL drop Req, return to IDLE, and emit o_Valid=1 with o_BusError=1 and RegWrite=0 for one cycle.
REQ-024 An ack arriving on the same cycle as the timeout SHALL win: a normal completion with no error.
REQ-025 i_DBus_Ack SHALL be ignored while in IDLE.

Reset
REQ-026 While i_Reset=0 at a clock edge: state=IDLE, counter=0, and o_DBus_Req, o_Valid, o_WB_Control.RegWrite, o_Misaligned and o_BusError SHALL all be 0.
REQ-027 While i_Reset=0, o_Stall SHALL be 0, and all data outputs SHALL be 0.
REQ-028 Reset during BUS SHALL abandon the access: Req=0 from the next cycle, and a late ack SHALL be ignored.

Structure
REQ-029 The FUNCT3 width constants and the mem-stage state enum SHALL live in the shared package alongside MEM_Control_t and WB_Control_t.
REQ-030 Lane steering and extension logic SHALL be one combinational sub-module, load_store_align.

Verification
REQ-031 LW at addr 0x100, ack on the first BUS cycle, RData=0xDEADBEEF -> o_Stall high 1 cycle; o_LoadData=0xDEADBEEF with o_Valid=1 two cycles after issue.
REQ-032 LB at 0x103, RData=0x80FFFFFF -> o_LoadData=0xFFFFFF80; LBU at the same address -> o_LoadData=0x00000080.
REQ-033 SH at 0x202, rs2=0x1234ABCD -> Addr=0x200, WData=0xABCDABCD, ByteEn=1100, We=1.
REQ-034 LW at 0x101 -> no Req, o_Misaligned=1, RegWrite=0, o_Stall=0.
REQ-035 LW with no ack, TIMEOUT_CYCLES=4 -> Req high 4 cycles, then o_BusError=1, Req=0, state IDLE.
REQ-036 Reset asserted in the 2nd BUS cycle, then ack pulsed -> Req=0, o_Valid=0, no writeback.
